event_window_counter: RTL and testbench

Parametrised successor to the per-cycle dual-threshold event counter. It takes the two event masks from the event-mask generator and counts per-cycle pulse and pile-up events through a configurable pipelined popcount tree. It then accumulates those counts over a programmable window of valid samples and reports window totals with a done strobe. It sits between event_mask_gen and the rate/readout logic.

---
 rtl/event_window_counter_pkg.sv | 20 ++
 rtl/event_window_counter_popcount_pipe.sv | 49 ++++
 rtl/event_window_counter.sv | 209 ++++++++++++++++++++
 tb/tb_event_window_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/event_window_counter_pkg.sv
// Shared helpers for event_window_counter: width derivations and window FSM state.
package event_pkg;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int pulse_w(input int n);
    return clog2(2 * n + 1);
  endfunction

  function automatic int pc_w(input int n);
    return clog2(n + 1);
  endfunction

  typedef enum logic {IDLE, RUN} win_state_e;

endpackage

// File: rtl/event_window_counter_popcount_pipe.sv
// Pipelined binary popcount tree, zero-padded to a power of two, with a register
// after every LEVELS_PER_STAGE adder levels and after the final level.
module popcount_pipe
  import event_pkg::*;
#(
  parameter int  NUM_CHANNELS     = 16,
  parameter int  LEVELS_PER_STAGE = 1,
  localparam int PC_W             = pc_w(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] mask_in,
  output logic [PC_W-1:0]         count_out
);
  localparam int LEVELS = clog2(NUM_CHANNELS);
  localparam int PAD    = 1 << LEVELS;
  localparam int STAGES = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  logic [PAD-1:0]  leaves;
  logic [PC_W-1:0] cur     [PAD];
  logic [PC_W-1:0] stage_d [STAGES][PAD];
  logic [PC_W-1:0] stage_q [STAGES][PAD];

  assign leaves = PAD'(mask_in);

  // Each stage reduces its node vector in place; node i of a level sums 2i and 2i+1 below.
  always_comb begin
    cur     = '{default: '0};
    stage_d = '{default: '0};
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < PAD; i++)
        cur[i] = (s == 0) ? PC_W'(leaves[i]) : stage_q[(s == 0) ? 0 : s - 1][i];
      for (int l = s * LEVELS_PER_STAGE + 1;
           l <= (((s + 1) * LEVELS_PER_STAGE < LEVELS) ? (s + 1) * LEVELS_PER_STAGE : LEVELS);
           l++)
        for (int i = 0; i < (PAD >> l); i++)
          cur[i] = cur[2 * i] + cur[2 * i + 1];
      stage_d[s] = cur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '{default: '0};
    else        stage_q <= stage_d;
  end

  assign count_out = stage_q[STAGES-1][0];

endmodule

// File: rtl/event_window_counter.sv
// Per-cycle pulse/pile-up counts plus accumulation over a window of valid samples.
// Define EVENT_CNT_SAT_EN for clamping accumulators and the win_sat output.
module event_window_counter
  import event_pkg::*;
#(
  parameter int  NUM_CHANNELS     = 16,
  parameter int  LEVELS_PER_STAGE = 1,
  parameter int  WIN_W            = 16,
  parameter int  CNT_W            = 32,
  localparam int PULSE_W          = pulse_w(NUM_CHANNELS),
  localparam int PC_W             = pc_w(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [NUM_CHANNELS-1:0] event_mask1,
  input  logic [NUM_CHANNELS-1:0] event_mask2,
  input  logic                    win_start,
  input  logic [WIN_W-1:0]        win_len,
  output logic [PULSE_W-1:0]      pulse_this_cycle,
  output logic [PC_W-1:0]         pileup_this_cycle,
  output logic                    valid_out,
  output logic                    win_active,
  output logic                    win_done,
  output logic                    win_partial,
  output logic [CNT_W-1:0]        win_pulse_total,
  output logic [CNT_W-1:0]        win_pileup_total,
  output logic [WIN_W-1:0]        win_samples
`ifdef EVENT_CNT_SAT_EN
  ,
  output logic                    win_sat
`endif
);
  localparam int TREE_STAGES = (clog2(NUM_CHANNELS) + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  logic [PC_W-1:0] pc1, pc2;

  popcount_pipe #(.NUM_CHANNELS(NUM_CHANNELS), .LEVELS_PER_STAGE(LEVELS_PER_STAGE)) u_pc1 (
    .clk(clk), .rst_n(rst_n), .mask_in(event_mask1), .count_out(pc1));
  popcount_pipe #(.NUM_CHANNELS(NUM_CHANNELS), .LEVELS_PER_STAGE(LEVELS_PER_STAGE)) u_pc2 (
    .clk(clk), .rst_n(rst_n), .mask_in(event_mask2), .count_out(pc2));

  // One sideband pipe serves both trees so window boundaries stay sample-aligned.
  logic [TREE_STAGES:1] vld_pipe_q, st_pipe_q;
  logic [WIN_W-1:0]     len_pipe_q [1:TREE_STAGES];
  logic                 out_vld_q, out_st_q;
  logic [WIN_W-1:0]     out_len_q;
  logic [PULSE_W-1:0]   pulse_q;
  logic [PC_W-1:0]      pileup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      st_pipe_q  <= '0;
      len_pipe_q <= '{default: '0};
      out_vld_q  <= 1'b0;
      out_st_q   <= 1'b0;
      out_len_q  <= '0;
      pulse_q    <= '0;
      pileup_q   <= '0;
    end else begin
      vld_pipe_q[1] <= valid_in;
      st_pipe_q[1]  <= valid_in & win_start;
      len_pipe_q[1] <= win_len;
      for (int i = 2; i <= TREE_STAGES; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        st_pipe_q[i]  <= st_pipe_q[i-1];
        len_pipe_q[i] <= len_pipe_q[i-1];
      end
      out_vld_q <= vld_pipe_q[TREE_STAGES];
      out_st_q  <= st_pipe_q[TREE_STAGES];
      out_len_q <= len_pipe_q[TREE_STAGES];
      pulse_q   <= PULSE_W'(pc1) + PULSE_W'(pc2);
      pileup_q  <= pc2;
    end
  end

  win_state_e       state_q, state_d;
  logic [CNT_W-1:0] acc_p_q, acc_p_d, acc_u_q, acc_u_d, sum_p, sum_u;
  logic [CNT_W-1:0] tot_p_q, tot_p_d, tot_u_q, tot_u_d;
  logic [WIN_W-1:0] cnt_q, cnt_d, wlen_q, wlen_d, samples_q, samples_d, cnt_inc;
  logic             done_q, done_d, partial_q, partial_d, running;

`ifdef EVENT_CNT_SAT_EN
  logic [CNT_W:0] sum_p_w, sum_u_w;
  logic           clamp, sat_q, sat_d, win_sat_q, win_sat_d;
  assign sum_p_w = {1'b0, acc_p_q} + (CNT_W+1)'(pulse_q);
  assign sum_u_w = {1'b0, acc_u_q} + (CNT_W+1)'(pileup_q);
  assign sum_p   = sum_p_w[CNT_W] ? '1 : sum_p_w[CNT_W-1:0];
  assign sum_u   = sum_u_w[CNT_W] ? '1 : sum_u_w[CNT_W-1:0];
  assign clamp   = sum_p_w[CNT_W] | sum_u_w[CNT_W];
`else
  assign sum_p = acc_p_q + CNT_W'(pulse_q);
  assign sum_u = acc_u_q + CNT_W'(pileup_q);
`endif
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIN_W'(1);

  always_comb begin
    state_d   = state_q;
    acc_p_d   = acc_p_q;
    acc_u_d   = acc_u_q;
    cnt_d     = cnt_q;
    wlen_d    = wlen_q;
    done_d    = 1'b0;
    partial_d = partial_q;
    tot_p_d   = tot_p_q;
    tot_u_d   = tot_u_q;
    samples_d = samples_q;
    running   = (state_q == RUN);
`ifdef EVENT_CNT_SAT_EN
    sat_d     = sat_q;
    win_sat_d = win_sat_q;
`endif
    // A full window left over from a restart with win_len=1 is reported first.
    if (running && wlen_q != '0 && cnt_q == wlen_q) begin
      done_d = 1'b1; partial_d = 1'b0; tot_p_d = acc_p_q; tot_u_d = acc_u_q;
      samples_d = cnt_q; state_d = IDLE; running = 1'b0;
`ifdef EVENT_CNT_SAT_EN
      win_sat_d = sat_q;
`endif
    end
    if (out_vld_q) begin
      if (out_st_q) begin
        if (running) begin
          done_d = 1'b1; partial_d = 1'b1; tot_p_d = acc_p_q; tot_u_d = acc_u_q;
          samples_d = cnt_q;
`ifdef EVENT_CNT_SAT_EN
          win_sat_d = sat_q;
`endif
        end
`ifdef EVENT_CNT_SAT_EN
        sat_d = 1'b0;
        if (!done_d) win_sat_d = 1'b0;
`endif
        acc_p_d = CNT_W'(pulse_q);
        acc_u_d = CNT_W'(pileup_q);
        cnt_d   = WIN_W'(1);
        wlen_d  = out_len_q;
        state_d = RUN;
        if (out_len_q == WIN_W'(1) && !done_d) begin
          done_d = 1'b1; partial_d = 1'b0; tot_p_d = CNT_W'(pulse_q);
          tot_u_d = CNT_W'(pileup_q); samples_d = WIN_W'(1); state_d = IDLE;
        end
      end else if (running) begin
        acc_p_d = sum_p;
        acc_u_d = sum_u;
        cnt_d   = cnt_inc;
`ifdef EVENT_CNT_SAT_EN
        sat_d   = sat_q | clamp;
`endif
        if (wlen_q != '0 && cnt_inc == wlen_q) begin
          done_d = 1'b1; partial_d = 1'b0; tot_p_d = sum_p; tot_u_d = sum_u;
          samples_d = cnt_inc; state_d = IDLE;
`ifdef EVENT_CNT_SAT_EN
          win_sat_d = sat_q | clamp;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_p_q   <= '0;
      acc_u_q   <= '0;
      cnt_q     <= '0;
      wlen_q    <= '0;
      done_q    <= 1'b0;
      partial_q <= 1'b0;
      tot_p_q   <= '0;
      tot_u_q   <= '0;
      samples_q <= '0;
`ifdef EVENT_CNT_SAT_EN
      sat_q     <= 1'b0;
      win_sat_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_p_q   <= acc_p_d;
      acc_u_q   <= acc_u_d;
      cnt_q     <= cnt_d;
      wlen_q    <= wlen_d;
      done_q    <= done_d;
      partial_q <= partial_d;
      tot_p_q   <= tot_p_d;
      tot_u_q   <= tot_u_d;
      samples_q <= samples_d;
`ifdef EVENT_CNT_SAT_EN
      sat_q     <= sat_d;
      win_sat_q <= win_sat_d;
`endif
    end
  end

  assign pulse_this_cycle  = pulse_q;
  assign pileup_this_cycle = pileup_q;
  assign valid_out         = out_vld_q;
  assign win_active        = (state_q == RUN);
  assign win_done          = done_q;
  assign win_partial       = partial_q;
  assign win_pulse_total   = tot_p_q;
  assign win_pileup_total  = tot_u_q;
  assign win_samples       = samples_q;
`ifdef EVENT_CNT_SAT_EN
  assign win_sat           = win_sat_q;
`endif

endmodule

// File: tb/tb_event_window_counter.sv
// Directed bench for event_window_counter: default, CNT_W=8 and N=20/LPS=2 instances.
module tb_event_window_counter;
  logic        clk = 1'b0, rst_n = 1'b0, valid_in = 1'b0, win_start = 1'b0;
  logic [15:0] win_len = '0, m1 = '0, m2 = '0;
  logic [19:0] n1 = '0, n2 = '0;

  logic [5:0]  pulse, pulse8, pulse20;
  logic [4:0]  pileup, pile8, pile20;
  logic        vout, active, done, partial, vout8, act8, done8, part8;
  logic        vout20, act20, done20, part20;
  logic [31:0] tp, tu, tp20, tu20;
  logic [7:0]  tp8, tu8;
  logic [15:0] ns, ns8, ns20;
`ifdef EVENT_CNT_SAT_EN
  logic        sat, sat8, sat20;
`endif

  int checks = 0, fails = 0, done_cnt = 0;
  logic [31:0] cap_p [16];
  logic [31:0] cap_u [16];
  logic [15:0] cap_n [16];
  logic        cap_part [16];

  event_window_counter dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .event_mask1(m1), .event_mask2(m2),
    .win_start(win_start), .win_len(win_len), .pulse_this_cycle(pulse),
    .pileup_this_cycle(pileup), .valid_out(vout), .win_active(active), .win_done(done),
    .win_partial(partial), .win_pulse_total(tp), .win_pileup_total(tu), .win_samples(ns)
`ifdef EVENT_CNT_SAT_EN
    , .win_sat(sat)
`endif
  );

  event_window_counter #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .event_mask1(m1), .event_mask2(m2),
    .win_start(win_start), .win_len(win_len), .pulse_this_cycle(pulse8),
    .pileup_this_cycle(pile8), .valid_out(vout8), .win_active(act8), .win_done(done8),
    .win_partial(part8), .win_pulse_total(tp8), .win_pileup_total(tu8), .win_samples(ns8)
`ifdef EVENT_CNT_SAT_EN
    , .win_sat(sat8)
`endif
  );

  event_window_counter #(.NUM_CHANNELS(20), .LEVELS_PER_STAGE(2)) dut20 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .event_mask1(n1), .event_mask2(n2),
    .win_start(win_start), .win_len(win_len), .pulse_this_cycle(pulse20),
    .pileup_this_cycle(pile20), .valid_out(vout20), .win_active(act20), .win_done(done20),
    .win_partial(part20), .win_pulse_total(tp20), .win_pileup_total(tu20), .win_samples(ns20)
`ifdef EVENT_CNT_SAT_EN
    , .win_sat(sat20)
`endif
  );

  always #5 clk = ~clk;

  // Captures every window report of the default instance.
  always @(negedge clk) begin
    if (done) begin
      if (done_cnt < 16) begin
        cap_p[done_cnt] = tp; cap_u[done_cnt] = tu;
        cap_n[done_cnt] = ns; cap_part[done_cnt] = partial;
      end
      done_cnt = done_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [15:0] len,
                       input logic [15:0] a, input logic [15:0] b);
    valid_in = v; win_start = st; win_len = len; m1 = a; m2 = b;
    cyc();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; win_start = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if ({pulse, pileup, vout, active, done, partial} !== '0) begin fails++; $display("FAIL reset_flags: got %h want 0", {pulse, pileup, vout, active, done, partial}); end
    checks++; if ({tp, tu, ns} !== '0) begin fails++; $display("FAIL reset_totals: got %h want 0", {tp, tu, ns}); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_latency();
    int seen = 0, at = 0;
    logic [5:0] gp = '0;
    logic [4:0] gu = '0;
    drive(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'hFFFF);
    valid_in = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      cyc();
      if (vout) begin seen++; at = k; gp = pulse; gu = pileup; end
    end
    checks++; if (seen != 1) begin fails++; $display("FAIL lat_pulses: got %0d want 1", seen); end
    checks++; if (at != 5) begin fails++; $display("FAIL lat_cycle: got %0d want 5", at); end
    checks++; if (gp !== 6'd32) begin fails++; $display("FAIL lat_pulse: got %0d want 32", gp); end
    checks++; if (gu !== 5'd16) begin fails++; $display("FAIL lat_pileup: got %0d want 16", gu); end
  endtask

  task automatic test_basic_window();
    int base = done_cnt;
    drive(1'b1, 1'b1, 16'd4, 16'h0003, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0001);
    drive(1'b0, 1'b0, 16'd0, 16'h0003, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0001);
    idle(10);
    checks++; if (done_cnt - base != 1) begin fails++; $display("FAIL basic_dones: got %0d want 1", done_cnt - base); end
    checks++; if (cap_p[base] !== 32'd12) begin fails++; $display("FAIL basic_pulse: got %0d want 12", cap_p[base]); end
    checks++; if (cap_u[base] !== 32'd4) begin fails++; $display("FAIL basic_pileup: got %0d want 4", cap_u[base]); end
    checks++; if (cap_n[base] !== 16'd4) begin fails++; $display("FAIL basic_samples: got %0d want 4", cap_n[base]); end
    checks++; if (cap_part[base] !== 1'b0) begin fails++; $display("FAIL basic_partial: got %0d want 0", cap_part[base]); end
    checks++; if (tp !== 32'd12 || active !== 1'b0) begin fails++; $display("FAIL basic_hold: got %0d/%0d want 12/0", tp, active); end
  endtask

  task automatic test_restart();
    int base = done_cnt;
    drive(1'b1, 1'b1, 16'd10, 16'h0003, 16'h0000);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0000);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0000);
    drive(1'b1, 1'b1, 16'd2, 16'h000F, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h000F, 16'h0001);
    idle(10);
    checks++; if (done_cnt - base != 2) begin fails++; $display("FAIL restart_dones: got %0d want 2", done_cnt - base); end
    checks++; if ({cap_p[base], cap_n[base], cap_part[base]} !== {32'd6, 16'd3, 1'b1}) begin fails++; $display("FAIL restart_first: got p=%0d n=%0d part=%0d want p=6 n=3 part=1", cap_p[base], cap_n[base], cap_part[base]); end
    checks++; if ({cap_p[base+1], cap_u[base+1], cap_n[base+1], cap_part[base+1]} !== {32'd10, 32'd2, 16'd2, 1'b0}) begin fails++; $display("FAIL restart_second: got p=%0d u=%0d n=%0d part=%0d want p=10 u=2 n=2 part=0", cap_p[base+1], cap_u[base+1], cap_n[base+1], cap_part[base+1]); end
  endtask

  task automatic test_len_one();
    int base = done_cnt;
    drive(1'b1, 1'b1, 16'd1, 16'h0001, 16'h0001);
    idle(10);
    checks++; if (done_cnt - base != 1) begin fails++; $display("FAIL len1_dones: got %0d want 1", done_cnt - base); end
    checks++; if ({cap_p[base], cap_u[base], cap_n[base], cap_part[base]} !== {32'd2, 32'd1, 16'd1, 1'b0}) begin fails++; $display("FAIL len1_report: got p=%0d u=%0d n=%0d want p=2 u=1 n=1", cap_p[base], cap_u[base], cap_n[base]); end
  endtask

  task automatic test_back_to_back();
    int base = done_cnt;
    drive(1'b1, 1'b1, 16'd5, 16'h0001, 16'h0000);
    drive(1'b1, 1'b1, 16'd1, 16'h0003, 16'h0000);
    drive(1'b1, 1'b1, 16'd1, 16'h0007, 16'h0000);
    idle(10);
    checks++; if (done_cnt - base != 3) begin fails++; $display("FAIL b2b_dones: got %0d want 3", done_cnt - base); end
    checks++; if ({cap_p[base], cap_part[base], cap_p[base+1], cap_part[base+1], cap_p[base+2]} !== {32'd1, 1'b1, 32'd2, 1'b0, 32'd3}) begin fails++; $display("FAIL b2b_reports: got %0d/%0d %0d/%0d %0d want 1/1 2/0 3", cap_p[base], cap_part[base], cap_p[base+1], cap_part[base+1], cap_p[base+2]); end
  endtask

  task automatic test_saturation();
`ifdef EVENT_CNT_SAT_EN
    logic [7:0] exp8 = 8'd255;
`else
    logic [7:0] exp8 = 8'd64;
`endif
    drive(1'b1, 1'b1, 16'd10, 16'hFFFF, 16'hFFFF);
    repeat (9) drive(1'b1, 1'b0, 16'd0, 16'hFFFF, 16'hFFFF);
    idle(10);
    checks++; if (tp8 !== exp8) begin fails++; $display("FAIL sat_pulse8: got %0d want %0d", tp8, exp8); end
    checks++; if ({tu8, ns8} !== {8'd160, 16'd10}) begin fails++; $display("FAIL sat_pileup8: got u=%0d n=%0d want u=160 n=10", tu8, ns8); end
    checks++; if (tp !== 32'd320) begin fails++; $display("FAIL sat_pulse32: got %0d want 320", tp); end
`ifdef EVENT_CNT_SAT_EN
    checks++; if ({sat8, sat} !== 2'b10) begin fails++; $display("FAIL sat_flag: got %b want 10", {sat8, sat}); end
`endif
  endtask

  task automatic test_reset_mid_window();
    int base;
    drive(1'b1, 1'b1, 16'd8, 16'h0003, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0001);
    drive(1'b1, 1'b0, 16'd0, 16'h0003, 16'h0001);
    idle(6);
    checks++; if (active !== 1'b1) begin fails++; $display("FAIL rst_active_before: got %0d want 1", active); end
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({tp, tu, ns, active, done, partial, vout, pulse} !== '0) begin fails++; $display("FAIL rst_outputs: got tp=%0d act=%0d vout=%0d want 0", tp, active, vout); end
    cyc(); cyc();
    rst_n = 1'b1;
    idle(12);
    checks++; if (done_cnt != base) begin fails++; $display("FAIL rst_no_done: got %0d want %0d", done_cnt, base); end
    drive(1'b1, 1'b1, 16'd2, 16'h0001, 16'h0000);
    drive(1'b1, 1'b0, 16'd0, 16'h0001, 16'h0000);
    idle(10);
    checks++; if (done_cnt - base != 1) begin fails++; $display("FAIL rst_next_dones: got %0d want 1", done_cnt - base); end
    checks++; if ({cap_p[base], cap_u[base], cap_n[base], cap_part[base]} !== {32'd2, 32'd0, 16'd2, 1'b0}) begin fails++; $display("FAIL rst_next_report: got p=%0d u=%0d n=%0d want p=2 u=0 n=2", cap_p[base], cap_u[base], cap_n[base]); end
  endtask

  task automatic test_non_pow2();
    int seen = 0, at = 0;
    logic [5:0] gp = '0;
    logic [4:0] gu = '1;
    n1 = 20'hFFFFF; n2 = '0;
    drive(1'b1, 1'b0, 16'd0, 16'h0000, 16'h0000);
    valid_in = 1'b0; n1 = '0;
    for (int k = 2; k <= 8; k++) begin
      cyc();
      if (vout20) begin seen++; at = k; gp = pulse20; gu = pile20; end
    end
    checks++; if (seen != 1 || at != 4) begin fails++; $display("FAIL np2_latency: got %0d pulses at %0d want 1 at 4", seen, at); end
    checks++; if ({gp, gu} !== {6'd20, 5'd0}) begin fails++; $display("FAIL np2_counts: got %0d/%0d want 20/0", gp, gu); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_basic_window();
    test_restart();
    test_len_one();
    test_back_to_back();
    test_saturation();
    test_reset_mid_window();
    test_non_pow2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
